// File: rtl/reindeer_instr_queue_pkg.sv
// Shared widths, queue entry layout and PC arithmetic for the instruction prefetch queue.
package reindeer_instr_queue_pkg;

  localparam int XLEN        = 32;
  localparam int PC_BITWIDTH = 32;

  localparam logic [PC_BITWIDTH-1:0] PC_STEP = PC_BITWIDTH'(4);

  typedef struct packed {
    logic [XLEN-1:0]        ir;
    logic [PC_BITWIDTH-1:0] pc;
  } instr_entry_t;

  // Sequential fetch address; wraps at the top of the address space.
  function automatic logic [PC_BITWIDTH-1:0] next_pc(input logic [PC_BITWIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/reindeer_instr_fifo_mem.sv
// DEPTH-entry storage for instruction/PC pairs: one write port, combinational read port.
module reindeer_instr_fifo_mem
  import reindeer_instr_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  instr_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output instr_entry_t               rdata
);

  instr_entry_t mem [DEPTH];

  // Entries are cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reindeer_instr_queue.sv
// Instruction prefetch queue: issues one fetch at a time, buffers returned words,
// and hands them to decode; a redirect flushes the queue and restarts fetch.
module reindeer_instr_queue
  import reindeer_instr_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   redirect,
  input  logic [PC_BITWIDTH-1:0] redirect_addr,
  output logic                   fetch_init,
  output logic [PC_BITWIDTH-1:0] start_addr,
  output logic                   fetch_next,
  input  logic                   fetch_enable_in,
  input  logic [XLEN-1:0]        IR_in,
  input  logic [PC_BITWIDTH-1:0] PC_in,
  output logic                   instr_valid,
  output logic [XLEN-1:0]        instr_IR,
  output logic [PC_BITWIDTH-1:0] instr_PC,
  input  logic                   instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_after;
  logic [PC_BITWIDTH-1:0] expected_pc;
  logic                   outstanding;
  logic                   push;
  logic                   pop;
  logic                   issue;
  instr_entry_t           wr_entry;
  instr_entry_t           rd_entry;

  // Decode handshake: the head transfers on any cycle where instr_valid and
  // instr_ready are both high; instr_valid never depends on instr_ready.
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;

  // Only the return matching expected_pc is kept; stale returns after a
  // redirect fail the PC check and are dropped.
  assign push = fetch_enable_in && (PC_in == expected_pc) && !redirect &&
                ((count != FULL) || pop);

  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  // A return accepted this cycle frees the single request slot, so the next
  // request can go out on the following edge as long as space remains.
  assign issue = !redirect && !fetch_init && !fetch_next &&
                 (!outstanding || push) && (count_after < FULL);

  assign wr_entry = '{ir: IR_in, pc: PC_in};
  assign instr_IR = rd_entry.ir;
  assign instr_PC = rd_entry.pc;

  reindeer_instr_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (sync_reset),
    .we      (push && !sync_reset),
    .waddr   (wr_ptr),
    .wdata   (wr_entry),
    .raddr   (rd_ptr),
    .rdata   (rd_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      expected_pc <= '0;
      outstanding <= 1'b0;
      fetch_init  <= 1'b0;
      start_addr  <= '0;
      fetch_next  <= 1'b0;
    end else if (sync_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      expected_pc <= '0;
      outstanding <= 1'b0;
      fetch_init  <= 1'b0;
      start_addr  <= '0;
      fetch_next  <= 1'b0;
    end else if (redirect) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      expected_pc <= redirect_addr;
      outstanding <= 1'b1;
      fetch_init  <= 1'b1;
      start_addr  <= redirect_addr;
      fetch_next  <= 1'b0;
    end else begin
      fetch_init <= 1'b0;
      fetch_next <= issue;
      count      <= count_after;
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        expected_pc <= next_pc(expected_pc);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (issue)     outstanding <= 1'b1;
      else if (push) outstanding <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reindeer_instr_queue.sv
// Directed bench for reindeer_instr_queue: the bench plays the fetch unit and
// decode; a monitor checks every popped word against an expected queue.
module tb_reindeer_instr_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        fetch_init;
  logic [31:0] start_addr;
  logic        fetch_next;
  logic        fetch_enable_in = 1'b0;
  logic [31:0] IR_in = '0;
  logic [31:0] PC_in = '0;
  logic        instr_valid;
  logic [31:0] instr_IR;
  logic [31:0] instr_PC;
  logic        instr_ready = 1'b0;

  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  reindeer_instr_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sync_reset      (sync_reset),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .fetch_init      (fetch_init),
    .start_addr      (start_addr),
    .fetch_next      (fetch_next),
    .fetch_enable_in (fetch_enable_in),
    .IR_in           (IR_in),
    .PC_in           (PC_in),
    .instr_valid     (instr_valid),
    .instr_IR        (instr_IR),
    .instr_PC        (instr_PC),
    .instr_ready     (instr_ready)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    redirect      = 1'b1;
    redirect_addr = addr;
    exp_q.delete();
    tick();
    redirect = 1'b0;
    check("redirect_fetch_init", 32'(fetch_init), 32'd1);
    check("redirect_start_addr", start_addr, addr);
  endtask

  task automatic ret(input logic [31:0] ir, input logic [31:0] pc, input bit acc);
    fetch_enable_in = 1'b1;
    IR_in           = ir;
    PC_in           = pc;
    if (acc) exp_q.push_back({ir, pc});
    tick();
    fetch_enable_in = 1'b0;
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (fetch_next || fetch_init) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_req: no fetch request within 16 cycles (got 0 expected 1)");
    end
  endtask

  // bench acts as memory with one cycle of latency
  task automatic serve(input logic [31:0] ir, input logic [31:0] pc);
    wait_req();
    tick();
    ret(ir, pc, 1'b1);
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && !sync_reset && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got PC 0x%08h expected no entry", instr_PC);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("pop_IR", instr_IR, e[63:32]);
        check("pop_PC", instr_PC, e[31:0]);
      end
    end
  end

  initial begin
    // reset
    repeat (3) tick();
    check("reset_instr_valid", 32'(instr_valid), 32'd0);
    check("reset_fetch_init", 32'(fetch_init), 32'd0);
    check("reset_start_addr", start_addr, 32'd0);
    check("reset_instr_IR", instr_IR, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_fetch_next", 32'(fetch_next), 32'd0);

    // first redirect and return
    do_redirect(32'h100);
    serve(32'h0000_0013, 32'h100);
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_PC", instr_PC, 32'h100);
    check("t1_IR", instr_IR, 32'h0000_0013);
    check("t1_fetch_next", 32'(fetch_next), 32'd1);

    // fill to DEPTH with decode stalled
    for (int k = 1; k < 4; k++) begin
      serve(32'h1000 + 32'(k), 32'h100 + 32'(4 * k));
      check("t2_fill_fetch_next", 32'(fetch_next), (k < 3) ? 32'd1 : 32'd0);
    end
    repeat (3) tick();
    check("t2_full_fetch_next", 32'(fetch_next), 32'd0);
    check("t2_head_PC", instr_PC, 32'h100);
    pop_one();
    check("t2_after_pop_fetch_next", 32'(fetch_next), 32'd1);
    serve(32'h1004, 32'h110);
    check("t2_refull_fetch_next", 32'(fetch_next), 32'd0);
    instr_ready = 1'b1;
    repeat (4) tick();
    instr_ready = 1'b0;
    check("t2_drained_valid", 32'(instr_valid), 32'd0);
    check("t2_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // redirect while a request is outstanding
    do_redirect(32'h100);
    serve(32'h2000, 32'h100);
    do_redirect(32'h200);
    check("t3_flushed_valid", 32'(instr_valid), 32'd0);
    ret(32'h2001, 32'h104, 1'b0);
    check("t3_stale_dropped", 32'(instr_valid), 32'd0);
    ret(32'h2002, 32'h200, 1'b1);
    check("t3_new_valid", 32'(instr_valid), 32'd1);
    check("t3_new_PC", instr_PC, 32'h200);
    check("t3_fetch_next", 32'(fetch_next), 32'd1);
    // old return coinciding with the redirect target, then its duplicate
    do_redirect(32'h204);
    tick();
    ret(32'h2003, 32'h204, 1'b1);
    check("t3_old_match_fetch_next", 32'(fetch_next), 32'd1);
    ret(32'h2004, 32'h204, 1'b0);
    check("t3_dup_valid", 32'(instr_valid), 32'd1);
    pop_one();
    check("t3_dup_dropped", 32'(instr_valid), 32'd0);

    // push and pop together at count 2
    do_redirect(32'h100);
    serve(32'h3000, 32'h100);
    serve(32'h3004, 32'h104);
    tick();
    fetch_enable_in = 1'b1;
    IR_in = 32'h3008;
    PC_in = 32'h108;
    exp_q.push_back({32'h3008, 32'h108});
    instr_ready = 1'b1;
    tick();
    fetch_enable_in = 1'b0;
    instr_ready = 1'b0;
    check("t4_head_PC", instr_PC, 32'h104);
    check("t4_fetch_next", 32'(fetch_next), 32'd1);
    pop_one();
    check("t4_one_left_valid", 32'(instr_valid), 32'd1);
    check("t4_one_left_PC", instr_PC, 32'h108);
    pop_one();
    check("t4_empty_valid", 32'(instr_valid), 32'd0);

    // redirect together with an accepted return and a pop
    ret(32'h300C, 32'h10C, 1'b1);
    check("t5_fetch_next", 32'(fetch_next), 32'd1);
    tick();
    fetch_enable_in = 1'b1;
    IR_in = 32'h3010;
    PC_in = 32'h110;
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 32'h300;
    exp_q.delete();
    tick();
    fetch_enable_in = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_start_addr", start_addr, 32'h300);
    ret(32'h3011, 32'h110, 1'b0);
    check("t5_old_dropped", 32'(instr_valid), 32'd0);
    ret(32'h3300, 32'h300, 1'b1);
    check("t5_new_PC", instr_PC, 32'h300);
    pop_one();

    // expected_pc wraps at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    serve(32'h4000, 32'hFFFF_FFFC);
    serve(32'h4004, 32'h0000_0000);
    check("wrap_head_PC", instr_PC, 32'hFFFF_FFFC);
    pop_one();
    check("wrap_second_PC", instr_PC, 32'h0000_0000);
    pop_one();
    check("wrap_empty", 32'(instr_valid), 32'd0);

    // synchronous reset
    do_redirect(32'h500);
    serve(32'h5000, 32'h500);
    sync_reset = 1'b1;
    exp_q.delete();
    tick();
    sync_reset = 1'b0;
    check("sync_reset_valid", 32'(instr_valid), 32'd0);
    check("sync_reset_fetch_next", 32'(fetch_next), 32'd0);
    check("sync_reset_start_addr", start_addr, 32'd0);
    repeat (3) tick();
    check("sync_reset_idle", 32'(fetch_next), 32'd0);

    // asynchronous reset mid-stream with 3 entries
    do_redirect(32'h400);
    serve(32'h6000, 32'h400);
    serve(32'h6004, 32'h404);
    serve(32'h6008, 32'h408);
    check("t6_fetch_next_before", 32'(fetch_next), 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_valid", 32'(instr_valid), 32'd0);
    check("t6_async_fetch_next", 32'(fetch_next), 32'd0);
    check("t6_async_fetch_init", 32'(fetch_init), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("t6_idle_fetch_next", 32'(fetch_next), 32'd0);
    check("t6_idle_valid", 32'(instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
